// File: rtl/conv_encoder_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_encoder_param
// Purpose  : Parametrised feed-forward convolutional encoder with fixed-length
//            frames and zero-tail termination. Valid/ready handshakes on both
//            sides; the output register holds its symbol under backpressure.
// Options  : PUNCTURE_EN - when defined, rate-2/3 puncturing of data symbols
//            (only meaningful for N_OUT == 2). Undefined: out_mask is all ones.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_param #(
    parameter int                 K         = 3,
    parameter int                 N_OUT     = 2,
    parameter logic [N_OUT*K-1:0] G         = 6'b101111,
    parameter int                 FRAME_LEN = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_sym,
    output logic [N_OUT-1:0] out_mask,
    output logic             out_tail,
    output logic             out_last
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // bit_cnt counts 0..FRAME_LEN-1, tail_cnt counts 0..K-2
    localparam int c_bit_cnt_w  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int c_tail_cnt_w = (K > 2) ? $clog2(K - 1) : 1;

    localparam logic [c_bit_cnt_w-1:0]  c_last_bit  = c_bit_cnt_w'(FRAME_LEN - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_bit_one   = c_bit_cnt_w'(1);
    localparam logic [c_tail_cnt_w-1:0] c_last_tail = c_tail_cnt_w'(K - 2);
    localparam logic [c_tail_cnt_w-1:0] c_tail_one  = c_tail_cnt_w'(1);
    localparam logic [N_OUT-1:0]        c_mask_all  = {N_OUT{1'b1}};

    typedef enum logic [0:0] {
        ST_ENC   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [K-2:0]            sr_q, sr_d;
    logic [c_bit_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic [c_tail_cnt_w-1:0] tail_cnt_q, tail_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [N_OUT-1:0]        out_sym_q, out_sym_d;
    logic [N_OUT-1:0]        out_mask_q, out_mask_d;
    logic                    out_tail_q, out_tail_d;
    logic                    out_last_q, out_last_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             free;       // output register can take a new symbol
    logic             enc_u;      // bit entering the window this cycle
    logic [K-1:0]     win;        // {sr, u}: win[0] newest, win[K-1] oldest
    logic [N_OUT-1:0] parity;     // encoded symbol for the current window
    logic [N_OUT-1:0] mask_data;  // mask applied to a data symbol
    logic             in_xfer;    // data bit accepted this cycle
    logic             last_bit;   // accepted bit is the final data bit

    assign free     = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign last_bit = (bit_cnt_q == c_last_bit);

    // Window and mod-2 generator taps; tail bits feed zeros into the window
    always_comb begin
        enc_u  = (state_q == ST_FLUSH) ? 1'b0 : in_bit;
        win    = {sr_q, enc_u};
        parity = '0;
        for (int j = 0; j < N_OUT; j++) begin
            parity[j] = ^(G[j*K +: K] & win);
        end
    end

`ifdef PUNCTURE_EN
    // ------------------------------------------------------------------------
    // Puncturing phase. Every data symbol leaves the output register exactly
    // once and in order, so advancing the phase when a data symbol is loaded
    // gives the same sequence as advancing it when that symbol is delivered,
    // while letting the mask be registered alongside the symbol.
    // ------------------------------------------------------------------------
    logic phase_q, phase_d;

    // Phase toggles per data symbol and restarts at 0 for every frame
    always_comb begin
        phase_d   = phase_q;
        mask_data = c_mask_all;
        if (in_xfer) begin
            phase_d = last_bit ? 1'b0 : ~phase_q;
        end
        if (phase_q) begin
            mask_data[N_OUT-1] = 1'b0;   // drop the second parity bit
        end
    end

    // Phase register
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    // No puncturing: every parity bit is transmitted
    assign mask_data = c_mask_all;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic: ENC accepts data bits, FLUSH emits K-1 zero-tail symbols
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_mask_d  = out_mask_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_ENC: begin
                in_ready = free && !RST;
                if (free) begin
                    // Held symbol (if any) is consumed this cycle
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_sym_d   = parity;
                        out_mask_d  = mask_data;
                        out_tail_d  = 1'b0;
                        out_last_d  = 1'b0;
                        sr_d        = win[K-2:0];
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            state_d   = ST_FLUSH;
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_bit_one;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                // Source must hold its bit; nothing is accepted while flushing
                if (free) begin
                    out_valid_d = 1'b1;
                    out_sym_d   = parity;
                    out_mask_d  = c_mask_all;
                    out_tail_d  = 1'b1;
                    if (tail_cnt_q == c_last_tail) begin
                        out_last_d = 1'b1;
                        sr_d       = '0;
                        tail_cnt_d = '0;
                        state_d    = ST_ENC;
                    end else begin
                        out_last_d = 1'b0;
                        sr_d       = win[K-2:0];
                        tail_cnt_d = tail_cnt_q + c_tail_one;
                    end
                end
            end

            default: begin
                state_d = ST_ENC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_ENC;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_mask_q  <= c_mask_all;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_mask_q  <= out_mask_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_mask  = out_mask_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire
